// File: rtl/key_loader_if.sv
// Serial key-store handshake between the OTP/eFuse shift port (master)
// and the key loader (slave).
interface key_loader_if;
  logic ser_valid;
  logic ser_data;
  logic ser_ready;

  modport master (output ser_valid, output ser_data, input ser_ready);
  modport slave  (input ser_valid, input ser_data, output ser_ready);
endinterface

// File: rtl/key_loader.sv
// Serially loads a parity-protected unlock key and presents it to a
// logic-locked netlist; a decoy key is driven until a verified key is held.
// Optional repeated-failure lockout: define KEY_LOADER_LOCKOUT_EN.
module key_loader #(
  parameter int unsigned           KEY_WIDTH = 2,
  parameter logic [KEY_WIDTH-1:0]  DECOY_KEY = '0,
  parameter int unsigned           MAX_FAIL  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  key_loader_if.slave          ser,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 error,
  output logic                 locked_out
);

  localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);

  if (KEY_WIDTH < 1 || KEY_WIDTH > 64 || MAX_FAIL < 1) begin : g_param_check
    $error("key_loader: KEY_WIDTH must be 1..64 and MAX_FAIL at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_DONE,
    S_FAIL
`ifdef KEY_LOADER_LOCKOUT_EN
    , S_LOCK
`endif
  } state_t;

  state_t               state, state_next;
  logic [KEY_WIDTH-1:0] shift, shift_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 xfer;
  logic                 ready_next;
  logic                 valid_next;
  logic                 error_next;
  logic [KEY_WIDTH-1:0] key_next;

`ifdef KEY_LOADER_LOCKOUT_EN
  localparam int unsigned FCNT_W = $clog2(MAX_FAIL + 1);

  logic [FCNT_W-1:0] fail, fail_next, fail_inc;
  logic              locked_next;
`endif

  assign xfer = ser.ser_valid & ser.ser_ready;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next = state;
    shift_next = shift;
    cnt_next   = cnt;
`ifdef KEY_LOADER_LOCKOUT_EN
    fail_next  = fail;
    fail_inc   = (fail == FCNT_W'(MAX_FAIL)) ? fail : fail + FCNT_W'(1);
`endif

    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_next = S_DATA;
          shift_next = '0;
          cnt_next   = '0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          for (int i = 0; i < KEY_WIDTH; i++) begin
            if (cnt == CNT_W'(i)) shift_next[i] = ser.ser_data;
          end
          cnt_next = cnt + CNT_W'(1);
          if (cnt == CNT_W'(KEY_WIDTH - 1)) state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (xfer) begin
          if (ser.ser_data == ^shift) begin
            state_next = S_DONE;
`ifdef KEY_LOADER_LOCKOUT_EN
            fail_next  = '0;
`endif
          end else begin
`ifdef KEY_LOADER_LOCKOUT_EN
            fail_next  = fail_inc;
            state_next = (fail_inc >= FCNT_W'(MAX_FAIL)) ? S_LOCK : S_FAIL;
`else
            state_next = S_FAIL;
`endif
          end
        end
      end
`ifdef KEY_LOADER_LOCKOUT_EN
      S_LOCK: state_next = S_LOCK;
`endif
      default: state_next = S_IDLE;
    endcase

    ready_next = (state_next == S_DATA) || (state_next == S_PARITY);
    valid_next = (state_next == S_DONE);
    // Shift reg reaches key only once the load is verified.
    key_next   = valid_next ? shift_next : DECOY_KEY;
`ifdef KEY_LOADER_LOCKOUT_EN
    locked_next = (state_next == S_LOCK);
    error_next  = (state_next == S_FAIL) || locked_next;
`else
    error_next  = (state_next == S_FAIL);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      shift         <= '0;
      cnt           <= '0;
      key           <= DECOY_KEY;
      key_valid     <= 1'b0;
      busy          <= 1'b0;
      ser.ser_ready <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_next;
      shift         <= shift_next;
      cnt           <= cnt_next;
      key           <= key_next;
      key_valid     <= valid_next;
      busy          <= ready_next;
      ser.ser_ready <= ready_next;
      error         <= error_next;
    end
  end

`ifdef KEY_LOADER_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail       <= '0;
      locked_out <= 1'b0;
    end else begin
      fail       <= fail_next;
      locked_out <= locked_next;
    end
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_key_loader;
  localparam int unsigned KW = 2;
  localparam int unsigned MF = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] key;
  logic          key_valid, busy, error, locked_out;

  key_loader_if ser ();

  key_loader #(.KEY_WIDTH(KW), .DECOY_KEY('0), .MAX_FAIL(MF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ser        (ser),
    .key        (key),
    .key_valid  (key_valid),
    .busy       (busy),
    .error      (error),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: a load is "open" from the start edge until the parity bit arrives.
  bit          m_loading, m_locked, m_valid, m_err, m_par;
  logic [KW-1:0] m_key;
  bit          m_bits[$];
  int          m_fails;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 0; m_locked = 0; m_valid = 0; m_err = 0;
      m_key = '0; m_fails = 0; m_bits.delete();
    end else if (!m_locked) begin
      if (!m_loading) begin
        if (start) begin
          m_loading = 1; m_bits.delete(); m_valid = 0; m_key = '0; m_err = 0;
        end
      end else if (ser.ser_valid) begin
        if (m_bits.size() < KW) begin
          m_bits.push_back(ser.ser_data);
        end else begin
          m_par = 0;
          foreach (m_bits[i]) m_par ^= m_bits[i];
          m_loading = 0;
          if (m_par == ser.ser_data) begin
            m_valid = 1;
            foreach (m_bits[i]) m_key[i] = m_bits[i];
            m_fails = 0;
          end else begin
            m_err = 1;
            if (m_fails < MF) m_fails++;
`ifdef KEY_LOADER_LOCKOUT_EN
            if (m_fails >= MF) m_locked = 1;
`endif
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("ser_ready",  64'(ser.ser_ready), 64'(m_loading));
        check("busy",       64'(busy),          64'(m_loading));
        check("key",        64'(key),           64'(m_key));
        check("key_valid",  64'(key_valid),     64'(m_valid));
        check("error",      64'(error),         64'(m_err || m_locked));
        check("locked_out", 64'(locked_out),    64'(m_locked));
      end
    end
  end

  task automatic drive(input bit s, input bit v, input bit d);
    @(negedge clk);
    start = s; ser.ser_valid = v; ser.ser_data = d;
  endtask

  // Start pulse, two key bits (LSB first) with optional stall, then parity.
  task automatic load(input bit b0, input bit b1, input bit p, input int stall);
    drive(1, 0, 0);
    drive(0, 1, b0);
    repeat (stall) drive(0, 0, 0);
    drive(0, 1, b1);
    repeat (stall) drive(0, 0, 0);
    drive(0, 1, p);
    drive(0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ser.ser_valid = 1'b0; ser.ser_data = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_key",   64'(key), 64'h0);
    check("rst_valid", 64'(key_valid), 64'h0);
    check("rst_ready", 64'(ser.ser_ready), 64'h0);
    rst = 1'b0;

    load(1, 0, 1, 0);
    check("good_key",   64'(key), 64'h1);
    check("good_valid", 64'(key_valid), 64'h1);
    check("good_error", 64'(error), 64'h0);

    load(1, 0, 1, 5);
    check("stall_key",   64'(key), 64'h1);
    check("stall_valid", 64'(key_valid), 64'h1);

    load(1, 1, 1, 0);
    check("bad_error", 64'(error), 64'h1);
    check("bad_valid", 64'(key_valid), 64'h0);
    check("bad_key",   64'(key), 64'h0);
    load(1, 1, 0, 0);
    check("retry_key",   64'(key), 64'h3);
    check("retry_error", 64'(error), 64'h0);

    // Restart from DONE, with an ignored start in the middle of DATA.
    drive(1, 0, 0);
    drive(0, 0, 0);
    check("reload_valid", 64'(key_valid), 64'h0);
    check("reload_key",   64'(key), 64'h0);
    check("reload_busy",  64'(busy), 64'h1);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(0, 1, 1);
    drive(0, 1, 1);
    drive(0, 0, 0);
    check("reload_new_key", 64'(key), 64'h2);
    check("reload_new_val", 64'(key_valid), 64'h1);

    // Asynchronous reset mid-DATA after one bit.
    drive(1, 0, 0);
    drive(0, 1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_key",   64'(key), 64'h0);
    check("arst_valid", 64'(key_valid), 64'h0);
    check("arst_busy",  64'(busy), 64'h0);
    check("arst_error", 64'(error), 64'h0);
    start = 1'b0; ser.ser_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);
    check("arst_idle_busy", 64'(busy), 64'h0);

`ifdef KEY_LOADER_LOCKOUT_EN
    repeat (MF) load(1, 1, 1, 0);
    check("lock_out",   64'(locked_out), 64'h1);
    check("lock_error", 64'(error), 64'h1);
    drive(1, 0, 0);
    drive(0, 0, 0);
    check("lock_ready", 64'(ser.ser_ready), 64'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    load(1, 0, 1, 0);
    check("unlock_key", 64'(key), 64'h1);
`endif

    repeat (600) begin
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        rst = 1'b1; start = 1'b0; ser.ser_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
      end
      drive($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drive(0, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
